// File: rtl/inst_fetch_buffer.sv
// Byte-serial instruction fetch: assembles big-endian 32-bit words from an 8-bit
// instruction memory into a small prefetch FIFO. Define INST_FETCH_BUFFER_COUNT_EN to add the inst_count pop counter.
module inst_fetch_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [4:0]  imem_addr,
    input  logic [7:0]  imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc,
`ifdef INST_FETCH_BUFFER_COUNT_EN
    output logic [31:0] inst_count,
`endif
    output logic [31:0] fetch_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // state | meaning
    // BYTE0 | sampling byte 0 (fetch_pc+0) into [31:24]
    // BYTE1 | sampling byte 1 (fetch_pc+1) into [23:16]
    // BYTE2 | sampling byte 2 (fetch_pc+2) into [15:8]
    // BYTE3 | sampling byte 3 and pushing the word; holds here while FIFO full
    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_fetch_pc;
    logic [7:0]     r_b0;
    logic [7:0]     r_b1;
    logic [7:0]     r_b2;
    logic [31:0]    r_mem_word [DEPTH];
    logic [31:0]    r_mem_pc   [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           w_pop;
    logic           w_has_room;
    logic           w_push;
    logic [31:0]    w_push_word;
    logic           w_unused;

    // Word alignment drops the low redirect bits.
    assign w_unused = ^redirect_pc[1:0];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BYTE0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_pop       = (r_count != '0) && inst_ready;
        w_has_room  = (r_count < DEPTH_C) || w_pop;
        w_push      = 1'b0;
        w_push_word = {r_b0, r_b1, r_b2, imem_rdata};
        w_state_nxt = r_state;
        case (r_state)
            BYTE0: w_state_nxt = BYTE1;
            BYTE1: w_state_nxt = BYTE2;
            BYTE2: w_state_nxt = BYTE3;
            BYTE3: begin
                if (w_has_room) begin
                    w_push      = 1'b1;
                    w_state_nxt = BYTE0;
                end
            end
            default: w_state_nxt = BYTE0;
        endcase
        if (redirect_valid) begin
            w_push      = 1'b0;
            w_state_nxt = BYTE0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_b0       <= '0;
            r_b1       <= '0;
            r_b2       <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            case (r_state)
                BYTE0:   r_b0 <= imem_rdata;
                BYTE1:   r_b1 <= imem_rdata;
                BYTE2:   r_b2 <= imem_rdata;
                default: ;
            endcase
            if (w_push) begin
                r_wr_ptr   <= next_ptr(r_wr_ptr);
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_word[r_wr_ptr] <= w_push_word;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

`ifdef INST_FETCH_BUFFER_COUNT_EN
    logic [31:0] r_pop_cnt;

    // A pop coinciding with a redirect is flushed, so it is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pop_cnt <= '0;
        end else if (w_pop && !redirect_valid) begin
            r_pop_cnt <= r_pop_cnt + 32'd1;
        end
    end

    assign inst_count = r_pop_cnt;
`endif

    assign imem_addr  = r_fetch_pc[4:0] + {3'b000, r_state};
    assign fetch_pc   = r_fetch_pc;
    assign inst_valid = (r_count != '0);
    assign inst_word  = inst_valid ? r_mem_word[r_rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of word entries in the prefetch FIFO (legal 2..8).
REQ-002 SHALL have parameter RESET_PC, default 32'h0: fetch address loaded on reset (bits [1:0] SHALL be 0).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port redirect_valid  input  1  flush buffer and restart fetch at redirect_pc.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address.
REQ-007 SHALL have port imem_addr  output  5  byte address to instruction memory.
REQ-008 SHALL have port imem_rdata  input  8  instruction memory byte, combinational, same cycle as imem_addr.
REQ-009 SHALL have port inst_valid  output  1  head FIFO entry available to decode.
REQ-010 SHALL have port inst_ready  input  1  decode accepts head entry.
REQ-011 SHALL have port inst_word  output  32  head instruction word.
REQ-012 SHALL have port inst_pc  output  32  byte address of head instruction.
REQ-013 SHALL have port fetch_pc  output  32  address of word currently being assembled.

Function
REQ-014 SHALL assemble words with a 4-state byte counter BYTE0..BYTE3; imem_addr = (fetch_pc + byte index)[4:0], wrapping modulo 32.
REQ-015 SHALL pack big-endian: BYTE0 byte -> [31:24], BYTE1 -> [23:16], BYTE2 -> [15:8], BYTE3 -> [7:0].
REQ-016 SHALL advance BYTE0->BYTE1->BYTE2->BYTE3 one state per cycle unconditionally.
REQ-017 In BYTE3, SHALL push {b0,b1,b2,imem_rdata} with pc=fetch_pc, set fetch_pc += 4 (wrap at 2^32), go to BYTE0, if FIFO count < DEPTH or a pop occurs the same cycle.
REQ-018 In BYTE3 with FIFO full and no pop, SHALL hold in BYTE3, keep fetch_pc, push nothing, re-sample imem_rdata next cycle.
REQ-019 A pop SHALL occur on a rising edge where inst_valid && inst_ready; inst_ready with inst_valid=0 SHALL have no effect.
REQ-020 inst_valid SHALL equal (count != 0); inst_word/inst_pc SHALL show the head entry, and 32'h0 when empty.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-022 Latency: with empty FIFO, a word SHALL be visible on inst_* the cycle after its BYTE3 edge (4 edges after fetch start).
REQ-023 redirect_valid SHALL dominate: FIFO cleared (count=0), state BYTE0, fetch_pc = {redirect_pc[31:2],2'b00}; any same-cycle push discarded; same-cycle pop is discarded with the rest.
REQ-024 Entries SHALL be delivered in strict fetch order; none lost or duplicated except by redirect.

Reset
REQ-025 On rst assertion, without waiting for clk: fetch_pc=RESET_PC, state BYTE0, count=0, inst_valid=0, inst_word=0, inst_pc=0, imem_addr=RESET_PC[4:0].
REQ-026 Reset mid-assembly SHALL discard partial bytes; first fetch after release starts at RESET_PC BYTE0.

Configuration
REQ-027 When macro INST_FETCH_BUFFER_COUNT_EN is defined, SHALL add output inst_count (32): number of pops since reset, reset 0, wraps at 2^32, unaffected by redirect.
REQ-028 When INST_FETCH_BUFFER_COUNT_EN is undefined, inst_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-029 Mem bytes 0..7 = 8C,22,00,04,AC,23,00,08, inst_ready=1, release reset -> inst_valid on 4th edge with inst_word=8C220004, inst_pc=0; 4 edges later AC230008, inst_pc=4.
REQ-030 inst_ready=0, DEPTH=2 -> count reaches 2, state holds BYTE3 with imem_addr=0x0B, fetch_pc=8; raising inst_ready -> words 0,4,8 delivered in order, none lost.
REQ-031 Full FIFO, inst_ready=1 on BYTE3 edge -> push and pop same edge, count stays 2.
REQ-032 redirect_valid with redirect_pc=32'h13 during BYTE2 with 1 entry -> next cycle inst_valid=0, fetch_pc=0x10, imem_addr=0x10; next word has inst_pc=0x10.
REQ-033 fetch_pc=0x1C -> bytes read from 1C,1D,1E,1F, next word from 0x20 with imem_addr=0x00 (wrap).
REQ-034 rst asserted mid-BYTE2 between edges -> outputs per REQ-025 immediately; with COUNT_EN after 3 pops then reset -> inst_count=0.
